// File: rtl/bus_pkg.sv
// Shared definitions for the cpu0 memory bus: FSM state codes, bus strobe
// encoding and the bus data width.
package bus_pkg;

   localparam int BUS_DW = 16;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_LOAD = 2'd1;
   localparam state_t ST_RUN  = 2'd2;

   localparam logic WR_READ  = 1'b1;
   localparam logic WR_WRITE = 1'b0;

endpackage

// File: rtl/bus_mem_if.sv
// Host preload channel of bus_mem: start pulse plus a valid/ready word stream
// terminated by load_last.
interface bus_mem_if
   import bus_pkg::*;
#(
   parameter int DW = BUS_DW
);
   logic          load_start;
   logic          load_valid;
   logic [DW-1:0] load_data;
   logic          load_last;
   logic          load_ready;

   modport master (output load_start, load_valid, load_data, load_last,
                   input  load_ready);
   modport slave  (input  load_start, load_valid, load_data, load_last,
                   output load_ready);
endinterface

// File: rtl/bus_mem_loader.sv
// Preload sequencer for bus_mem: IDLE/LOAD/RUN FSM, load pointer and host
// handshake; emits the array write port used while the CPU is held.
module bus_mem_loader
   import bus_pkg::*;
#(
   parameter int AW = 8,
   parameter int DW = BUS_DW
) (
   input  logic          clk,
   input  logic          reset,
   bus_mem_if.slave      ld,
   output logic          cpu_hold,
   output logic          run,
   output logic [AW-1:0] load_ptr,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata
);

   state_t        state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // NOTE: defaults first so no path through the case leaves a variable
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (ld.load_start) begin
               state_d = ST_LOAD;
               ptr_d   = '0;
            end
         end
         ST_LOAD: begin
            // A restart wins over a beat arriving in the same cycle.
            if (ld.load_start) begin
               ptr_d = '0;
            end else if (ld.load_valid) begin
               if (ld.load_last || (&ptr_q)) begin
                  state_d = ST_RUN;
                  ptr_d   = '0;
               end else begin
                  ptr_d = ptr_q + 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (ld.load_start) begin
               state_d = ST_LOAD;
               ptr_d   = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            ptr_d   = '0;
         end
      endcase
   end

   always_comb begin
      cpu_hold      = (state_q != ST_RUN);
      run           = (state_q == ST_RUN);
      ld.load_ready = (state_q == ST_LOAD);
      mem_we        = (state_q == ST_LOAD) && ld.load_valid && !ld.load_start;
      mem_addr      = ptr_q;
      mem_wdata     = ld.load_data;
      load_ptr      = ptr_q;
   end

endmodule

// File: rtl/bus_mem.sv
// Word-addressed RAM on the cpu0 bus: combinational reads, clocked writes,
// host preload. Optional CPU write protection: BUS_MEM_WRITE_PROTECT_EN.
module bus_mem
   import bus_pkg::*;
#(
   parameter int AW = 8,
   parameter int DW = BUS_DW
`ifdef BUS_MEM_WRITE_PROTECT_EN
   ,parameter logic [15:0] RO_TOP = 16'h0000
`endif
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [15:0]   address_bus,
   inout  wire  [DW-1:0] data_bus,
   input  logic          wr,
   bus_mem_if.slave      ld,
   output logic          cpu_hold,
   output logic [AW-1:0] load_ptr
`ifdef BUS_MEM_WRITE_PROTECT_EN
   ,output logic         wp_fault
`endif
);

   localparam int DEPTH = 2 ** AW;

   logic          run;
   logic          ld_we;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_wdata;
   logic          in_range;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] rd_data;
   logic          cpu_wr_req;
   logic          cpu_we;

   logic [DW-1:0] mem [DEPTH];

   bus_mem_loader #(.AW(AW), .DW(DW)) u_loader (
      .clk       (clk),
      .reset     (reset),
      .ld        (ld),
      .cpu_hold  (cpu_hold),
      .run       (run),
      .load_ptr  (load_ptr),
      .mem_we    (ld_we),
      .mem_addr  (ld_addr),
      .mem_wdata (ld_wdata)
   );

   assign in_range   = ((address_bus >> AW) == 16'd0);
   assign cpu_addr   = address_bus[AW-1:0];
   assign rd_data    = in_range ? mem[cpu_addr] : '0;
   assign cpu_wr_req = run && (wr == WR_WRITE) && in_range;

   // Bus is driven only for a CPU read in RUN; otherwise it floats.
   assign data_bus = (run && (wr == WR_READ)) ? rd_data : {DW{1'bz}};

`ifdef BUS_MEM_WRITE_PROTECT_EN
   logic wp_hit;
   assign wp_hit = (address_bus <= RO_TOP);
   assign cpu_we = cpu_wr_req && !wp_hit;

   always_ff @(posedge clk) begin
      if (reset) wp_fault <= 1'b0;
      else       wp_fault <= cpu_wr_req && wp_hit;
   end
`else
   assign cpu_we = cpu_wr_req;
`endif

   // NOTE: the array has no reset; contents survive reset so a partial
   // image stays in place, and it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (ld_we)       mem[ld_addr]  <= ld_wdata;
      else if (cpu_we) mem[cpu_addr] <= data_bus;
   end

endmodule

// File: tb/tb_bus_mem.sv
// Self-checking bench for bus_mem: directed preload/bus steps plus random CPU
// traffic against an array model; a pullup makes a floating bus read 16'hFFFF.
module tb_bus_mem;
   import bus_pkg::*;

   localparam int AW    = 8;
   localparam int DEPTH = 256;
   localparam logic [15:0] FLOAT = 16'hFFFF;
`ifdef BUS_MEM_WRITE_PROTECT_EN
   localparam logic [15:0] RO_TOP = 16'h000F;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [15:0]   address_bus = '0;
   wire  [15:0]   data_bus;
   logic          wr = WR_READ;
   logic          drv_en = 1'b0;
   logic [15:0]   drv_val = '0;
   logic          cpu_hold;
   logic [AW-1:0] load_ptr;
`ifdef BUS_MEM_WRITE_PROTECT_EN
   logic          wp_fault;
`endif

   bus_mem_if #(.DW(16)) ld ();

   assign data_bus = drv_en ? drv_val : 16'hzzzz;
   pullup (data_bus);

   bus_mem #(
      .AW(AW), .DW(16)
`ifdef BUS_MEM_WRITE_PROTECT_EN
      ,.RO_TOP(RO_TOP)
`endif
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .address_bus (address_bus),
      .data_bus    (data_bus),
      .wr          (wr),
      .ld          (ld),
      .cpu_hold    (cpu_hold),
      .load_ptr    (load_ptr)
`ifdef BUS_MEM_WRITE_PROTECT_EN
      ,.wp_fault   (wp_fault)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: plain array plus the preload pointer the host expects.
   logic [15:0] mdl [DEPTH];
   bit          known [DEPTH];
   int          mptr;
   int          checks = 0;
   int          failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_ctl(input string tag, input logic hold, input logic rdy, input int ptr);
      check({tag, ".cpu_hold"}, 32'(cpu_hold), 32'(hold));
      check({tag, ".load_ready"}, 32'(ld.load_ready), 32'(rdy));
      check({tag, ".load_ptr"}, 32'(load_ptr), 32'(ptr));
   endtask

   task automatic start_load();
      ld.load_start = 1'b1;
      step();
      ld.load_start = 1'b0;
      mptr = 0;
   endtask

   task automatic beat(input logic [15:0] d, input logic last);
      ld.load_valid = 1'b1;
      ld.load_data  = d;
      ld.load_last  = last;
      step();
      ld.load_valid = 1'b0;
      ld.load_last  = 1'b0;
      mdl[mptr]   = d;
      known[mptr] = 1'b1;
      mptr = (last || mptr == DEPTH - 1) ? 0 : mptr + 1;
   endtask

   // Combinational read: no clock edge is consumed.
   task automatic read_chk(input logic [15:0] a, input string tag);
      wr = WR_READ;
      drv_en = 1'b0;
      address_bus = a;
      #1;
      if ((a >> AW) != 0)
         check(tag, 32'(data_bus), 32'h0);
      else if (known[a[AW-1:0]])
         check(tag, 32'(data_bus), 32'(mdl[a[AW-1:0]]));
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [15:0] d, input string tag);
      bit prot;
      wr = WR_WRITE;
      address_bus = a;
      drv_en = 1'b1;
      drv_val = d;
      #1;
      check({tag, ".bus_released"}, 32'(data_bus), 32'(d));
      step();
      drv_en = 1'b0;
      wr = WR_READ;
      prot = 1'b0;
`ifdef BUS_MEM_WRITE_PROTECT_EN
      prot = (a <= RO_TOP);
      check({tag, ".wp_fault"}, 32'(wp_fault), 32'(prot));
`endif
      if ((a >> AW) == 0 && !prot) begin
         mdl[a[AW-1:0]]   = d;
         known[a[AW-1:0]] = 1'b1;
      end
   endtask

   initial begin
      logic [15:0] a, d;
      logic [15:0] keep2;

      ld.load_start = 1'b0;
      ld.load_valid = 1'b0;
      ld.load_data  = '0;
      ld.load_last  = 1'b0;
      for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
      mptr = 0;

      // Reset into IDLE.
      step();
      step();
      reset = 1'b0;
      #1;
      check_ctl("reset", 1'b1, 1'b0, 0);
      check("idle.bus_z", 32'(data_bus), 32'(FLOAT));

      // Three-beat image, last on the third beat.
      start_load();
      check_ctl("load_entry", 1'b1, 1'b1, 0);
      check("load.bus_z", 32'(data_bus), 32'(FLOAT));
      beat(16'h1111, 1'b0);
      beat(16'h2222, 1'b0);
      check_ctl("load_beat2", 1'b1, 1'b1, 2);
      beat(16'h3333, 1'b1);
      check_ctl("run_entry", 1'b0, 1'b0, 0);

      // Zero-latency reads.
      read_chk(16'h0001, "read1");
      read_chk(16'h0002, "read2");
      read_chk(16'h0000, "read0");

      // CPU write then read back.
      cpu_write(16'h0010, 16'hBEEF, "wr_beef");
      read_chk(16'h0010, "read_beef");

      // Out-of-range accesses.
      read_chk(16'h0100, "oor_read");
      cpu_write(16'h0100, 16'h5555, "oor_write");
      read_chk(16'h0000, "oor_no_alias");
      read_chk(16'h8001, "oor_read_hi");

      // Low-address write: suppressed only with write protection.
      cpu_write(16'h0003, 16'hA5A5, "wr_low");
      read_chk(16'h0003, "read_low");
`ifdef BUS_MEM_WRITE_PROTECT_EN
      step();
      check("wp_fault_pulse_end", 32'(wp_fault), 32'h0);
`endif

      // Full-depth stream without load_last.
      start_load();
      check_ctl("reload_entry", 1'b1, 1'b1, 0);
      for (int i = 0; i < DEPTH; i++) begin
         if (i == DEPTH - 1) check_ctl("stream_last", 1'b1, 1'b1, DEPTH - 1);
         beat(16'($urandom), 1'b0);
      end
      check_ctl("stream_run", 1'b0, 1'b0, 0);
      for (int i = 0; i < DEPTH; i++) read_chk(16'(i), $sformatf("stream_rd%0d", i));

      // Random CPU traffic.
      for (int i = 0; i < 60; i++) begin
         a = ($urandom_range(0, 9) < 2) ? 16'($urandom) : {8'h00, 8'($urandom)};
         d = 16'($urandom);
         if ($urandom_range(0, 1) == 1) read_chk(a, $sformatf("rnd_rd%0d", i));
         else                           cpu_write(a, d, $sformatf("rnd_wr%0d", i));
      end

      // load_start mid-load wins over a simultaneous beat.
      keep2 = mdl[2];
      start_load();
      beat(16'hA000, 1'b0);
      beat(16'hA001, 1'b0);
      ld.load_start = 1'b1;
      ld.load_valid = 1'b1;
      ld.load_data  = 16'hDEAD;
      step();
      ld.load_start = 1'b0;
      ld.load_valid = 1'b0;
      mptr = 0;
      check_ctl("restart", 1'b1, 1'b1, 0);
      beat(16'hB000, 1'b1);
      check_ctl("restart_run", 1'b0, 1'b0, 0);
      read_chk(16'h0000, "restart_rd0");
      read_chk(16'h0001, "restart_rd1");
      wr = WR_READ;
      address_bus = 16'h0002;
      #1;
      check("restart_dropped", 32'(data_bus), 32'(keep2));

      // Reset mid-load keeps the partial image.
      start_load();
      for (int i = 0; i < 5; i++) beat(16'hC000 + 16'(i), 1'b0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_ctl("reset_mid_load", 1'b1, 1'b0, 0);
      check("reset_idle.bus_z", 32'(data_bus), 32'(FLOAT));
      start_load();
      beat(16'hD000, 1'b1);
      check_ctl("after_reset_run", 1'b0, 1'b0, 0);
      for (int i = 0; i < 5; i++) read_chk(16'(i), $sformatf("partial_rd%0d", i));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
